// File: rtl/event_capture_pkg.sv
// Shared edge-mode constants, FSM state encoding and edge-detect helper
// for the event edge capture front end.
package event_capture_pkg;

   localparam int EDGE_ANY  = 0;
   localparam int EDGE_RISE = 1;
   localparam int EDGE_FALL = 2;

   typedef logic [0:0] state_t;

   localparam state_t EMPTY = 1'b0;
   localparam state_t FULL  = 1'b1;

   // s is the current synchronised level, p the level one cycle earlier.
   function automatic logic edge_detect(input int mode, input logic s, input logic p);
      case (mode)
         EDGE_RISE: return s & ~p;
         EDGE_FALL: return ~s & p;
         default:   return s ^ p;
      endcase
   endfunction

endpackage

// File: rtl/event_sync_edge.sv
// Synchroniser chain plus edge detector: emits a registered 1-cycle edge pulse.
// Latency: input change before edge N -> pulse high after edge N+SYNC_STAGES.
// Backpressure: none, free-running; pulses are never held back.
module event_sync_edge
   import event_capture_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_ANY
) (
   input  logic clk,
   input  logic rst_n,
   input  logic event_in,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_lvl;
   logic                   edge_now;

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign edge_now = edge_detect(EDGE_MODE, sync_lvl, prev_q);

   // prev_q resets to 0 so a line held high through reset still yields one rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], event_in};
         prev_q     <= sync_lvl;
         edge_pulse <= edge_now;
      end
   end

endmodule

// File: rtl/event_edge_capture.sv
// Captures load_val on each detected event edge into a one-entry valid/ready holding register.
// Latency: event change before edge N -> out_valid after edge N+SYNC_STAGES+1.
// Backpressure: while full and not ready, new edges are dropped and flagged sticky in overflow.
// Optional EVENT_CAPTURE_TIMESTAMP_EN adds out_time, a free-running cycle count latched with out_data.
module event_edge_capture
   import event_capture_pkg::*;
#(
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_ANY,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              event_in,
   input  logic [DATA_W-1:0] load_val,
   input  logic              out_ready,
   input  logic              clr_ovf,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  edge_cnt,
   output logic              overflow
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   ,
   output logic [CNT_W-1:0]  out_time
`endif
);

   logic   edge_pulse;
   logic   handshake;
   logic   load;
   logic   drop;
   state_t state_q;
   state_t state_d;

   event_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
   ) u_sync_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .event_in   (event_in),
      .edge_pulse (edge_pulse)
   );

   assign out_valid = (state_q == FULL);
   assign handshake = out_valid & out_ready;
   // A slot is free when empty or when the current entry leaves this cycle.
   assign load      = edge_pulse & (!out_valid | out_ready);
   assign drop      = edge_pulse & out_valid & !out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (edge_pulse) state_d = FULL;
         FULL:    if (handshake && !edge_pulse) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         out_data <= '0;
      end else begin
         state_q <= state_d;
         if (load) out_data <= load_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
      end else if (edge_pulse && (edge_cnt != {CNT_W{1'b1}})) begin
         edge_cnt <= edge_cnt + 1'b1;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   logic [CNT_W-1:0] cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         out_time  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (load) out_time <= cycle_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_event_edge_capture.sv
// Directed bench for event_edge_capture: table-driven capture/hold/drop sequence
// plus hand-written reset, edge-mode and saturation scenarios.
module tb_event_edge_capture;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       ev = 1'b0;
   logic [3:0] ld = 4'h0;
   logic       rdy = 1'b0;
   logic       clr = 1'b0;
   logic       v0;
   logic [3:0] d0;
   logic [7:0] c0;
   logic       o0;

   logic       ev2 = 1'b0;
   logic [3:0] ld2 = 4'hC;
   logic       rdy2 = 1'b1;
   logic       clr2 = 1'b0;
   logic       vr, vs;
   logic [3:0] dr, ds;
   logic [7:0] cr;
   logic [1:0] cs;
   logic       orr, os;

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   logic [7:0] t0, tr;
   logic [1:0] ts;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   event_edge_capture #(.DATA_W(4), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .event_in(ev), .load_val(ld), .out_ready(rdy), .clr_ovf(clr),
      .out_valid(v0), .out_data(d0), .edge_cnt(c0), .overflow(o0)
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
      , .out_time(t0)
`endif
   );

   event_edge_capture #(.DATA_W(4), .SYNC_STAGES(2), .EDGE_MODE(1), .CNT_W(8)) dut_rise (
      .clk(clk), .rst_n(rst_n), .event_in(ev2), .load_val(ld2), .out_ready(rdy2), .clr_ovf(clr2),
      .out_valid(vr), .out_data(dr), .edge_cnt(cr), .overflow(orr)
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
      , .out_time(tr)
`endif
   );

   event_edge_capture #(.DATA_W(4), .SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .event_in(ev2), .load_val(ld2), .out_ready(rdy2), .clr_ovf(clr2),
      .out_valid(vs), .out_data(ds), .edge_cnt(cs), .overflow(os)
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
      , .out_time(ts)
`endif
   );

   typedef struct {
      logic       ev;
      logic [3:0] ld;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [3:0] d;
      logic [7:0] c;
      logic       o;
   } vec_t;

   vec_t vecs[$];
   int   rise_caps = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic add(input logic e, input logic [3:0] l, input logic r, input logic c,
                      input logic xv, input logic [3:0] xd, input logic [7:0] xc, input logic xo);
      vec_t t;
      t.ev = e; t.ld = l; t.rdy = r; t.clr = c;
      t.v = xv; t.d = xd; t.c = xc; t.o = xo;
      vecs.push_back(t);
   endtask

   task automatic step2(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (vr) rise_caps++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      //   ev  ld  rdy clr | valid data cnt ovf
      add(0, 4'h5, 0, 0,   0, 4'h0, 0, 0);
      add(0, 4'h5, 0, 0,   0, 4'h0, 0, 0);
      add(1, 4'h5, 0, 0,   0, 4'h0, 0, 0);
      add(1, 4'h5, 0, 0,   0, 4'h0, 0, 0);
      add(1, 4'h5, 0, 0,   0, 4'h0, 0, 0);
      add(1, 4'h5, 0, 0,   1, 4'h5, 1, 0);
      add(1, 4'h5, 0, 0,   1, 4'h5, 1, 0);
      add(0, 4'hA, 0, 0,   1, 4'h5, 1, 0);
      add(0, 4'hA, 0, 0,   1, 4'h5, 1, 0);
      add(0, 4'hA, 0, 0,   1, 4'h5, 1, 0);
      add(0, 4'hA, 0, 0,   1, 4'h5, 2, 1);
      add(0, 4'hA, 0, 1,   1, 4'h5, 2, 0);
      add(0, 4'hA, 0, 0,   1, 4'h5, 2, 0);
      add(1, 4'h3, 0, 0,   1, 4'h5, 2, 0);
      add(1, 4'h3, 0, 0,   1, 4'h5, 2, 0);
      add(1, 4'h3, 0, 0,   1, 4'h5, 2, 0);
      add(1, 4'h3, 1, 0,   1, 4'h3, 3, 0);
      add(1, 4'h3, 1, 0,   0, 4'h3, 3, 0);
      add(1, 4'h3, 0, 0,   0, 4'h3, 3, 0);
      add(0, 4'h7, 0, 0,   0, 4'h3, 3, 0);
      add(0, 4'h7, 0, 0,   0, 4'h3, 3, 0);
      add(0, 4'h7, 0, 0,   0, 4'h3, 3, 0);
      add(0, 4'h7, 0, 0,   1, 4'h7, 4, 0);
      add(1, 4'h9, 0, 0,   1, 4'h7, 4, 0);
      add(1, 4'h9, 0, 0,   1, 4'h7, 4, 0);
      add(1, 4'h9, 0, 0,   1, 4'h7, 4, 0);
      add(1, 4'h9, 0, 1,   1, 4'h7, 5, 1);
      add(1, 4'h9, 0, 0,   1, 4'h7, 5, 1);
      add(1, 4'h9, 1, 0,   0, 4'h7, 5, 1);

      // Reset held while event_in toggles: nothing may be captured.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ev = ~ev;
         ld = 4'hF;
         @(posedge clk);
         #1;
         if (k == 1 || k == 3)
            check($sformatf("reset_hold%0d", k), {31'd0, v0} | {27'd0, d0, 1'b0} | {19'd0, c0, 5'd0} | {18'd0, o0, 13'd0}, 0);
      end
      @(negedge clk);
      ev = 1'b0;
      ld = 4'h5;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) @(posedge clk);
      #1;
      check("post_reset_valid", {31'd0, v0}, 0);
      check("post_reset_cnt", {24'd0, c0}, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         ev  = vecs[i].ev;
         ld  = vecs[i].ld;
         rdy = vecs[i].rdy;
         clr = vecs[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d {valid,data,cnt,ovf}", i), {18'd0, v0, d0, c0, o0},
               {18'd0, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].o});
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
         if (i == 5) check("out_time_at_capture", {24'd0, t0}, 32'd10);
`endif
      end

      // Mid-operation reset with event_in held high: one edge after release.
      @(negedge clk);
      ev = 1'b1;
      ld = 4'hE;
      rdy = 1'b0;
      clr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_ovf", {31'd0, o0}, 0);
      check("midreset_cnt", {24'd0, c0}, 0);
      check("midreset_data", {28'd0, d0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 11;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (v0) begin
            cyc = k;
            break;
         end
      end
      check("high_through_reset_latency", cyc, 4);
      check("high_through_reset_data", {28'd0, d0}, 32'hE);
      check("high_through_reset_cnt", {24'd0, c0}, 1);

      // Rising-only vs any-change with a saturating 2-bit counter.
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ev2 = k[0];
         step2(6);
         check($sformatf("rise_cnt_after%0d", k), {24'd0, cr}, (k + 1) / 2);
         check($sformatf("rise_caps_after%0d", k), rise_caps, (k + 1) / 2);
         check($sformatf("sat_cnt_after%0d", k), {30'd0, cs}, (k < 3) ? k : 3);
      end
      check("rise_data", {28'd0, dr}, 32'hC);
      check("sat_ovf", {31'd0, os}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
